// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants, state encoding and helpers for frame_wr_arbiter
//
// Purpose: default parameters, FSM state codes and small index helpers used by
// the frame write arbiter and its round-robin picker.
package fifo_arb_pkg;

  // Default parameter values for frame_wr_arbiter.
  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int AW_DEF         = 9;
  localparam int LEN_W_DEF      = 11;

  // Idle cycles after every frame so the FIFO occupancy catches up with the
  // last registered write before the next free-space check.
  localparam int GAP_CYCLES = 2;

  // FSM state encoding.
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 3'd0;
  localparam arb_state_t ST_ARB  = 3'd1;
  localparam arb_state_t ST_XFER = 3'd2;
  localparam arb_state_t ST_DROP = 3'd3;
  localparam arb_state_t ST_GAP  = 3'd4;

  // Index reached by stepping k places upward from s, wrapping at n.
  function automatic int wrap_idx(input int s, input int k, input int n);
    return (s + k) % n;
  endfunction

endpackage

// File: rtl/frame_wr_arbiter_rr_pick.sv
// rtl/frame_wr_arbiter_rr_pick.sv - combinational round-robin one-hot picker
//
// Purpose: pick the first asserted request searching upward from 'start' with
// wrap-around.
// Ports:
//   req     in  N   request vector
//   start   in  IW  index where the search begins (last winner + 1)
//   gnt_oh  out N   one-hot pick, zero when nothing is requested
//   gnt_idx out IW  index of the pick, zero when nothing is requested
//   found   out 1   at least one request was present
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          found
);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_idx(int'(start), k, N)]) begin
        found                               = 1'b1;
        gnt_oh[wrap_idx(int'(start), k, N)] = 1'b1;
        gnt_idx                             = IW'(wrap_idx(int'(start), k, N));
      end
    end
  end

endmodule

// File: rtl/frame_wr_arbiter.sv
// rtl/frame_wr_arbiter.sv - round-robin frame arbiter feeding one DC_FIFO write port
//
// Purpose: lets NUM_REQ frame sources share a FIFO write port. A frame is only
// granted when the FIFO has room for its whole declared length, so a granted
// frame never waits on space mid-way except for transient FifoWrFull.
// Ports:
//   SysClk      in   1                   clock, shared with the FIFO write side
//   Reset_N     in   1                   synchronous active-low reset
//   ReqValid    in   NUM_REQ             requester presents a word
//   ReqLen      in   NUM_REQ*LEN_W       declared frame length in words
//   ReqData     in   NUM_REQ*DATA_WIDTH  word data
//   ReqLast     in   NUM_REQ             last word of the frame
//   ReqReady    out  NUM_REQ             word accepted on ReqValid & ReqReady
//   FifoWrEn    out  1                   FIFO write enable (registered)
//   FifoWrData  out  DATA_WIDTH          FIFO write data (registered)
//   FifoWrDNum  in   AW                  FIFO write-side occupancy
//   FifoWrFull  in   1                   FIFO full
//   Grant       out  NUM_REQ             one-hot current owner
//   LenErr      out  1                   pulse on rejected or mis-sized frame
module frame_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int AW         = AW_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                          SysClk,
  input  logic                          Reset_N,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [NUM_REQ*LEN_W-1:0]      ReqLen,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
  input  logic [NUM_REQ-1:0]            ReqLast,
  output logic [NUM_REQ-1:0]            ReqReady,
  output logic                          FifoWrEn,
  output logic [DATA_WIDTH-1:0]         FifoWrData,
  input  logic [AW-1:0]                 FifoWrDNum,
  input  logic                          FifoWrFull,
  output logic [NUM_REQ-1:0]            Grant,
  output logic                          LenErr
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CAP = (1 << AW) - 1;

  // Length arithmetic is done one bit wider than the length field so lengths
  // above the FIFO capacity compare correctly.
  localparam logic [LEN_W:0]  CAP_W   = (LEN_W + 1)'(CAP);
  localparam logic [LEN_W:0]  CNT_ONE = (LEN_W + 1)'(1);
  localparam logic [IW-1:0]   IDX_ONE = IW'(1);
  localparam logic [IW-1:0]   IDX_MAX = IW'(NUM_REQ - 1);
  localparam logic [1:0]      GAP_END = 2'(GAP_CYCLES - 1);

  arb_state_t                state_q,   state_d;
  logic [IW-1:0]             ptr_q,     ptr_d;
  logic [NUM_REQ-1:0]        grant_q,   grant_d;
  logic [IW-1:0]             gidx_q,    gidx_d;
  logic [LEN_W-1:0]          len_q,     len_d;
  logic [LEN_W:0]            cnt_q,     cnt_d;
  logic [1:0]                gap_q,     gap_d;
  logic                      wr_en_q,   wr_en_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      lenerr_q,  lenerr_d;

  // Round-robin candidate among the currently valid requesters.
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req     (ReqValid),
    .start   (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .found   (pick_found)
  );

  // Candidate length checks against the FIFO capacity and current free space.
  logic [LEN_W-1:0] pick_len;
  logic [LEN_W:0]   pick_len_w;
  logic [LEN_W:0]   free_w;
  logic             len_bad;
  logic             len_fits;

  assign pick_len   = ReqLen[int'(pick_idx)*LEN_W +: LEN_W];
  assign pick_len_w = {1'b0, pick_len};
  assign free_w     = CAP_W - (LEN_W + 1)'(FifoWrDNum);
  assign len_bad    = (pick_len == '0) || (pick_len_w > CAP_W);
  assign len_fits   = (pick_len_w <= free_w);

  // Signals of the current owner.
  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  accept;
  logic [NUM_REQ-1:0]    ready_w;
  logic [LEN_W:0]        cnt_inc;
  logic [IW-1:0]         ptr_next;

  assign cur_valid = ReqValid[gidx_q];
  assign cur_last  = ReqLast[gidx_q];
  assign cur_data  = ReqData[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];

  // DROP swallows words regardless of FifoWrFull since nothing is written.
  always_comb begin
    ready_w = '0;
    if (state_q == ST_XFER && !FifoWrFull) begin
      ready_w = grant_q;
    end else if (state_q == ST_DROP) begin
      ready_w = grant_q;
    end
  end

  assign ReqReady = ready_w;
  assign accept   = cur_valid & ready_w[gidx_q];

  // Saturates so an over-long frame can never wrap back to a matching count.
  assign cnt_inc  = (&cnt_q) ? cnt_q : (cnt_q + CNT_ONE);
  assign ptr_next = (pick_idx == IDX_MAX) ? '0 : (pick_idx + IDX_ONE);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    lenerr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|ReqValid) begin
          state_d = ST_ARB;
        end
      end

      ST_ARB: begin
        if (!pick_found) begin
          state_d = ST_IDLE;
        end else if (len_bad) begin
          // The frame is owned only long enough to drain it.
          state_d  = ST_DROP;
          grant_d  = pick_oh;
          gidx_d   = pick_idx;
          ptr_d    = ptr_next;
          lenerr_d = 1'b1;
        end else if (len_fits) begin
          state_d = ST_XFER;
          grant_d = pick_oh;
          gidx_d  = pick_idx;
          len_d   = pick_len;
          cnt_d   = '0;
          ptr_d   = ptr_next;
        end
        // Not enough room: hold with the pointer unchanged so this candidate
        // keeps priority until the FIFO drains.
      end

      ST_XFER: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_q < {1'b0, len_q}) begin
            wr_en_d   = 1'b1;
            wr_data_d = cur_data;
          end
          if (cur_last) begin
            state_d  = ST_GAP;
            grant_d  = '0;
            gap_d    = '0;
            lenerr_d = (cnt_inc != {1'b0, len_q});
          end
        end
      end

      ST_DROP: begin
        if (accept && cur_last) begin
          state_d = ST_GAP;
          grant_d = '0;
          gap_d   = '0;
        end
      end

      ST_GAP: begin
        gap_d = gap_q + 2'd1;
        if (gap_q == GAP_END) begin
          state_d = (|ReqValid) ? ST_ARB : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (!Reset_N) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      lenerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      lenerr_q  <= lenerr_d;
    end
  end

  assign Grant      = grant_q;
  assign FifoWrEn   = wr_en_q;
  assign FifoWrData = wr_data_q;
  assign LenErr     = lenerr_q;

endmodule

// File: tb/tb_frame_wr_arbiter.sv
// tb/tb_frame_wr_arbiter.sv - randomized self-checking bench for frame_wr_arbiter
module tb_frame_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 9;
  localparam int LW  = 11;
  localparam int CAP = 511;

  logic              SysClk = 1'b0;
  logic              Reset_N;
  logic [N-1:0]      ReqValid, ReqLast, ReqReady, Grant;
  logic [N*LW-1:0]   ReqLen;
  logic [N*DW-1:0]   ReqData;
  logic              FifoWrEn, FifoWrFull, LenErr;
  logic [DW-1:0]     FifoWrData;
  logic [AW-1:0]     FifoWrDNum;

  always #5 SysClk = ~SysClk;

  frame_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .AW         (AW),
    .LEN_W      (LW)
  ) dut (
    .SysClk     (SysClk),
    .Reset_N    (Reset_N),
    .ReqValid   (ReqValid),
    .ReqLen     (ReqLen),
    .ReqData    (ReqData),
    .ReqLast    (ReqLast),
    .ReqReady   (ReqReady),
    .FifoWrEn   (FifoWrEn),
    .FifoWrData (FifoWrData),
    .FifoWrDNum (FifoWrDNum),
    .FifoWrFull (FifoWrFull),
    .Grant      (Grant),
    .LenErr     (LenErr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Requester frames: declared length, word count and pending words per source.
  int            flen[N][$];
  int            fnw[N][$];
  logic [DW-1:0] fwd[N][$];
  int            pos[N];

  // Reference model of ownership and round-robin order.
  int           owner;
  int           rr_start;
  logic [N-1:0] acc;
  bit           gap_ref, chk_gap, rand_gaps, rand_full;
  int           gap_cnt, full_cnt;
  int           n_wr, n_lenerr, n_rdy_low, exp_lenerr_total;
  int           grant_log[$];

  function automatic bit bad_len(input int l);
    return (l == 0) || (l > CAP);
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (flen[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_frame(input int i, input int len, input int nw);
    flen[i].push_back(len);
    fnw[i].push_back(nw);
    for (int k = 0; k < nw; k++) fwd[i].push_back(DW'($urandom));
    if (bad_len(len) || nw != len) exp_lenerr_total++;
  endtask

  task automatic tick();
    bit           exp_wr, exp_le;
    logic [DW-1:0] exp_d;
    logic [N-1:0] exp_grant, exp_rdy, v_v, l_v;
    logic [N*LW-1:0] len_v;
    logic [N*DW-1:0] dat_v;
    int           w, l;
    @(negedge SysClk);
    exp_wr = 1'b0; exp_d = '0; exp_le = 1'b0;
    // Consequences of the word accepted at the last edge.
    if (owner >= 0 && acc[owner]) begin
      l = flen[owner][0];
      if (!bad_len(l) && pos[owner] < l) begin
        exp_wr = 1'b1;
        exp_d  = fwd[owner][0];
      end
      void'(fwd[owner].pop_front());
      pos[owner]++;
      if (pos[owner] == fnw[owner][0]) begin
        if (!bad_len(l) && fnw[owner][0] != l) exp_le = 1'b1;
        void'(flen[owner].pop_front());
        void'(fnw[owner].pop_front());
        pos[owner] = 0;
        owner      = -1;
        gap_cnt    = 0;
        gap_ref    = any_pending();
      end
    end
    chk("wr_en", FifoWrEn, exp_wr);
    if (exp_wr) chk("wr_data", FifoWrData, exp_d);
    if (FifoWrEn) n_wr++;
    // A new grant must go to the first source with a frame, from rr_start up.
    if (owner < 0 && Grant != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && flen[(rr_start + k) % N].size() > 0) w = (rr_start + k) % N;
      chk("grant_pick", Grant, (w >= 0) ? (32'd1 << w) : 32'd0);
      if (chk_gap && gap_ref) chk("gap_len", gap_cnt, 3);
      if (w >= 0) begin
        owner    = w;
        rr_start = (w + 1) % N;
        gap_ref  = 1'b0;
        grant_log.push_back(w);
        if (bad_len(flen[w][0])) exp_le = 1'b1;
      end
    end else if (owner < 0) begin
      gap_cnt++;
    end
    exp_grant = '0;
    if (owner >= 0) exp_grant[owner] = 1'b1;
    chk("grant", Grant, exp_grant);
    chk("lenerr", LenErr, exp_le);
    if (LenErr) n_lenerr++;
    // Drive the next words.
    v_v = '0; l_v = '0; len_v = '0; dat_v = '0;
    for (int i = 0; i < N; i++) begin
      if (flen[i].size() > 0 && !(rand_gaps && pos[i] > 0 && $urandom_range(7) == 0)) begin
        v_v[i]             = 1'b1;
        l_v[i]             = (pos[i] == fnw[i][0] - 1);
        len_v[i*LW +: LW]  = LW'(flen[i][0]);
        dat_v[i*DW +: DW]  = fwd[i][0];
      end
    end
    ReqValid   = v_v;
    ReqLast    = l_v;
    ReqLen     = len_v;
    ReqData    = dat_v;
    FifoWrFull = (full_cnt > 0) || (rand_full && $urandom_range(5) == 0);
    if (full_cnt > 0) full_cnt--;
    #1;
    exp_rdy = '0;
    if (owner >= 0) exp_rdy[owner] = bad_len(flen[owner][0]) ? 1'b1 : !FifoWrFull;
    chk("ready", ReqReady, exp_rdy);
    if (owner >= 0 && !bad_len(flen[owner][0]) && ReqValid[owner] && !ReqReady[owner])
      n_rdy_low++;
    acc = ReqValid & ReqReady;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge SysClk);
    Reset_N = 1'b0;
    ReqValid = '0; ReqLast = '0; ReqLen = '0; ReqData = '0;
    FifoWrFull = 1'b0; FifoWrDNum = '0;
    for (int i = 0; i < N; i++) begin
      flen[i].delete(); fnw[i].delete(); fwd[i].delete(); pos[i] = 0;
    end
    owner = -1; rr_start = 0; acc = '0; gap_ref = 1'b0; full_cnt = 0;
    repeat (cycles) @(negedge SysClk);
    chk("rst_grant", Grant, 0);
    chk("rst_ready", ReqReady, 0);
    chk("rst_wr_en", FifoWrEn, 0);
    chk("rst_wr_data", FifoWrData, 0);
    chk("rst_lenerr", LenErr, 0);
    Reset_N = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    int t;
    t = 0;
    while ((owner >= 0 || any_pending()) && t < budget) begin
      tick();
      t++;
    end
    chk("done_in_budget", (t < budget), 1);
    repeat (4) tick();
  endtask

  task automatic clear_stats();
    n_wr = 0; n_lenerr = 0; n_rdy_low = 0;
    grant_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, consec;
    Reset_N = 1'b0;
    ReqValid = '0; ReqLast = '0; ReqLen = '0; ReqData = '0;
    FifoWrFull = 1'b0; FifoWrDNum = '0;
    chk_gap = 1'b0; rand_gaps = 1'b0; rand_full = 1'b0;
    exp_lenerr_total = 0; gap_cnt = 0;
    do_reset(3);

    // Single requester, 10-word frame.
    clear_stats();
    add_frame(0, 10, 10);
    run_until_idle(200);
    chk("t1_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk("t1_writes", n_wr, 10);
    chk("t1_lenerr", n_lenerr, 0);

    // Fairness with all requesters continuously busy.
    do_reset(1);
    clear_stats();
    chk_gap = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < N; i++) add_frame(i, 4, 4);
    run_until_idle(2000);
    chk("fair_count", grant_log.size(), 16);
    for (int k = 0; k < 5; k++)
      chk("fair_order", (grant_log.size() > k) ? grant_log[k] : -1, k % N);
    consec = 0;
    for (int k = 1; k < grant_log.size(); k++)
      if (grant_log[k] == grant_log[k-1]) consec++;
    chk("fair_no_repeat", consec, 0);
    chk("fair_writes", n_wr, 64);

    // Space stall: 11 words free, 20 requested.
    chk_gap = 1'b0;
    clear_stats();
    FifoWrDNum = 9'd500;
    add_frame(1, 20, 20);
    repeat (6) tick();
    chk("space_hold", Grant, 0);
    FifoWrDNum = 9'd480;
    tick();
    chk("space_grant", Grant, 4'b0010);
    run_until_idle(200);
    chk("space_writes", n_wr, 20);
    FifoWrDNum = '0;

    // FifoWrFull for 3 cycles mid-frame.
    clear_stats();
    add_frame(3, 12, 12);
    t = 0;
    while (!(owner == 3 && pos[3] >= 4) && t < 200) begin tick(); t++; end
    chk("full_reach", (t < 200), 1);
    full_cnt = 3;
    run_until_idle(200);
    chk("full_stall_cycles", n_rdy_low, 3);
    chk("full_writes", n_wr, 12);

    // Length errors and length boundaries.
    clear_stats();
    add_frame(2, 0, 3);
    run_until_idle(200);
    chk("len0_writes", n_wr, 0);
    chk("len0_lenerr", n_lenerr, 1);
    clear_stats();
    add_frame(2, 8, 6);
    run_until_idle(200);
    chk("short_writes", n_wr, 6);
    chk("short_lenerr", n_lenerr, 1);
    clear_stats();
    add_frame(0, CAP + 1, 2);
    run_until_idle(200);
    chk("overcap_writes", n_wr, 0);
    chk("overcap_lenerr", n_lenerr, 1);
    clear_stats();
    add_frame(1, CAP, 3);
    run_until_idle(200);
    chk("cap_writes", n_wr, 3);
    chk("cap_lenerr", n_lenerr, 1);
    clear_stats();
    add_frame(3, 5, 7);
    run_until_idle(200);
    chk("long_writes", n_wr, 5);
    chk("long_lenerr", n_lenerr, 1);

    // Reset in the middle of a transfer.
    clear_stats();
    add_frame(2, 10, 10);
    t = 0;
    while (!(owner == 2 && pos[2] >= 3) && t < 200) begin tick(); t++; end
    chk("rst_reach", (t < 200), 1);
    do_reset(1);
    clear_stats();
    add_frame(3, 4, 4);
    add_frame(0, 4, 4);
    run_until_idle(200);
    chk("rst_next_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk("rst_writes", n_wr, 8);

    // Randomized mix with valid gaps, full pulses and length errors.
    clear_stats();
    exp_lenerr_total = 0;
    chk_gap = 1'b1; rand_gaps = 1'b1; rand_full = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        int kind, len;
        kind = $urandom_range(9);
        case (kind)
          0: add_frame(i, 0, $urandom_range(1, 3));
          1: add_frame(i, $urandom_range(CAP + 1, 2047), $urandom_range(1, 3));
          2: begin len = $urandom_range(1, 12); add_frame(i, len, len + $urandom_range(1, 3)); end
          3: begin len = $urandom_range(2, 12); add_frame(i, len, $urandom_range(1, len - 1)); end
          default: begin len = $urandom_range(1, 12); add_frame(i, len, len); end
        endcase
      end
    end
    run_until_idle(20000);
    chk("rand_lenerr_total", n_lenerr, exp_lenerr_total);
    chk("rand_frames", grant_log.size(), 6 * N);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_wr_arbiter.md
FRAME_WR_ARBITER -- requirements
Module: frame_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of frame requesters sharing one DC_FIFO write port.
REQ-002 Parameter DATA_WIDTH, default 8: word width, equal to the FIFO DATA_WIDTH.
REQ-003 Parameter AW, default 9: FIFO address width; capacity CAP = 2**AW - 1 words.
REQ-004 Parameter LEN_W, default 11: width of each frame-length field.
REQ-005 SysClk  in  1  single clock, shared with the FIFO write clock.
REQ-006 Reset_N  in  1  synchronous, active-low reset.
REQ-007 ReqValid  in  NUM_REQ  requester i presents a word.
REQ-008 ReqLen  in  NUM_REQ*LEN_W  frame length in words; stable while ReqValid[i] is high and the frame is not granted.
REQ-009 ReqData  in  NUM_REQ*DATA_WIDTH  word data.
REQ-010 ReqLast  in  NUM_REQ  last word of the frame.
REQ-011 ReqReady  out  NUM_REQ  word accepted when ReqValid[i] and ReqReady[i] are both high.
REQ-012 FifoWrEn  out  1  FIFO write enable.
REQ-013 FifoWrData  out  DATA_WIDTH  FIFO write data.
REQ-014 FifoWrDNum  in  AW  FIFO write-side occupancy.
REQ-015 FifoWrFull  in  1  FIFO full.
REQ-016 Grant  out  NUM_REQ  one-hot current owner, all zero when no owner.
REQ-017 LenErr  out  1  one-cycle pulse when a frame is rejected or truncated.

Function
REQ-018 FSM states: IDLE, ARB, XFER, DROP, GAP.
REQ-019 IDLE -> ARB when any ReqValid is high.
REQ-020 ARB does a round-robin pick, searching upward from last winner + 1 with wrap; after reset the search starts at index 0.
REQ-021 ARB free-space check: free = CAP - FifoWrDNum, compared at LEN_W+1 bits.
REQ-022 ARB with ReqLen = 0 or ReqLen > CAP: go to DROP, assert Grant, pulse LenErr.
REQ-023 ARB with ReqLen > free (and the length otherwise valid): stay in ARB, no Grant, re-evaluate every cycle; the pointer does not advance, so the candidate keeps priority.
REQ-024 ARB otherwise: go to XFER, Grant one-hot, winner pointer updated.
REQ-025 XFER: ReqReady[g] = Grant[g] AND NOT FifoWrFull; all other ReqReady bits are 0.
REQ-026 XFER write path: each accepted word is registered onto FifoWrData with FifoWrEn high one cycle later (latency 1).
REQ-027 XFER keeps an internal word counter; accepted words beyond ReqLen are consumed without a FIFO write.
REQ-028 XFER end: an accepted ReqLast ends the frame; if count != ReqLen, LenErr pulses in the cycle after ReqLast.
REQ-029 DROP: ReqReady[g] = 1 and no FIFO writes until ReqLast is accepted, then -> GAP.
REQ-030 GAP lasts exactly 2 cycles with Grant cleared, so FifoWrDNum reflects the final writes; then -> ARB if any ReqValid, else IDLE.
REQ-031 Grant only changes on frame boundaries; no preemption.
REQ-032 FifoWrFull asserted mid-frame stalls acceptance only; state and counter hold.
REQ-033 Requester ReqValid dropping mid-frame: the arbiter waits; there is no timeout.

Reset
REQ-034 While Reset_N = 0 at a SysClk edge: state IDLE, rr pointer so the next search starts at 0, counter 0.
REQ-035 Outputs under reset: Grant 0, ReqReady 0, FifoWrEn 0, FifoWrData 0, LenErr 0.
REQ-036 Reset mid-frame abandons the frame with no further writes; the FIFO reset is the integrator's responsibility.

Structure
REQ-037 Shared package fifo_arb_pkg holds the state enumeration, GAP_CYCLES = 2 and default parameters.
REQ-038 One sub-module, rr_pick: combinational round-robin one-hot picker (request vector, last-grant pointer -> one-hot, index).

Verification
REQ-039 Single-requester frame: Req0 sends a 10-word frame, ReqLen=10, empty FIFO -> Grant=0001, 10 FifoWrEn pulses with data in order, 1-cycle latency, LenErr 0.
REQ-040 Fairness: all 4 requesters continuously send 4-word frames -> grant order 0,1,2,3,0; no requester gets two consecutive grants.
REQ-041 Space stall: FifoWrDNum=500, AW=9, Req1 ReqLen=20 -> held in ARB; FifoWrDNum driven to 480 -> grant next cycle.
REQ-042 Full stall: FifoWrFull pulsed for 3 cycles mid-frame -> ReqReady low exactly those cycles; no lost or duplicated words.
REQ-043 Length errors: ReqLen=0 -> DROP, LenErr pulse, zero writes. ReqLen=8 with ReqLast on word 6 -> 6 writes, LenErr pulse.
REQ-044 Reset mid-XFER: Reset_N low for 1 cycle -> all outputs 0 next cycle; IDLE; next grant goes to index 0.
